encoder_4x2_reg: RTL and testbench

- Registered 4-to-2 priority encoder; inverse of the 2x4 decoder in the same challenge set.
- Converts a one-hot (or multi-hot) 4-bit request vector into a 2-bit index.
- Single-entry output register with valid/ready handshake on both sides, a zero-input flag and a saturating error counter.
- Sits between a request source and the decoder/consumer, so that a decoder-to-encoder round trip is testable.

---
 rtl/encoder_4x2_reg_if.sv | 39 +++
 rtl/encoder_4x2_reg.sv | 108 ++++++++++
 tb/tb_encoder_4x2_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/encoder_4x2_reg_if.sv
// Request/result handshake bundle for encoder_4x2_reg.
// The multi flag exists only when ONEHOT_CHECK_EN is defined.
interface encoder_4x2_reg_if #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 2,
    parameter int CNT_W     = 8
);
    logic [WIDTH_IN-1:0]  in;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH_OUT-1:0] out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 zero;
    logic [CNT_W-1:0]     err_cnt;
`ifdef ONEHOT_CHECK_EN
    logic                 multi;

    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, zero, err_cnt, multi
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, zero, err_cnt, multi
    );
`else
    modport master (
        output in, in_valid, out_ready,
        input  in_ready, out, out_valid, zero, err_cnt
    );

    modport slave (
        input  in, in_valid, out_ready,
        output in_ready, out, out_valid, zero, err_cnt
    );
`endif
endinterface

// File: rtl/encoder_4x2_reg.sv
// Registered 4-to-2 priority encoder (MSB wins) with a one-entry valid/ready output stage,
// zero flag and saturating error counter. ONEHOT_CHECK_EN adds multi-hot detection (multi).
module encoder_4x2_reg #(
    parameter int WIDTH_IN  = 4,
    parameter int WIDTH_OUT = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    encoder_4x2_reg_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH_OUT-1:0] out_q, out_d;
    logic                 zero_q, zero_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 accept;
    logic                 err;
`ifdef ONEHOT_CHECK_EN
    logic                 multi_q, multi_d;
`endif

    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (accept) state_d = FULL;
            FULL:  if (bus.out_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A full stage still accepts when the consumer drains it in the same cycle.
    always_comb begin
        bus.out_valid = (state_q == FULL);
        bus.in_ready  = !bus.out_valid || bus.out_ready;
        bus.out       = out_q;
        bus.zero      = zero_q;
        bus.err_cnt   = err_cnt_q;
`ifdef ONEHOT_CHECK_EN
        bus.multi     = multi_q;
`endif
    end

    always_comb begin
        out_d  = WIDTH_OUT'(0);
        zero_d = 1'b0;
        if (bus.in[3])      out_d = WIDTH_OUT'(3);
        else if (bus.in[2]) out_d = WIDTH_OUT'(2);
        else if (bus.in[1]) out_d = WIDTH_OUT'(1);
        else if (bus.in[0]) out_d = WIDTH_OUT'(0);
        else                zero_d = 1'b1;
    end

`ifdef ONEHOT_CHECK_EN
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    always_comb begin
        multi_d = (bus.in & (bus.in - 1'b1)) != '0;
        err     = zero_d || multi_d;
    end
`else
    always_comb begin
        err = zero_d;
    end
`endif

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && err && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            zero_q    <= 1'b0;
            err_cnt_q <= '0;
`ifdef ONEHOT_CHECK_EN
            multi_q   <= 1'b0;
`endif
        end else begin
            err_cnt_q <= err_cnt_d;
            if (accept) begin
                out_q  <= out_d;
                zero_q <= zero_d;
`ifdef ONEHOT_CHECK_EN
                multi_q <= multi_d;
`endif
            end
        end
    end

endmodule

// File: tb/tb_encoder_4x2_reg.sv
// Directed, table-driven bench for encoder_4x2_reg: streaming, backpressure,
// zero/multi-hot errors, counter saturation and asynchronous reset.
module tb_encoder_4x2_reg;

    typedef struct {
        logic [3:0] in;
        logic [1:0] out;
        logic       zero;
        logic       multi;
    } vec_t;

`ifdef ONEHOT_CHECK_EN
    localparam bit ONEHOT = 1'b1;
`else
    localparam bit ONEHOT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   expErr;
    vec_t vecs[10];

    encoder_4x2_reg_if #(.WIDTH_IN(4), .WIDTH_OUT(2), .CNT_W(8)) busIf ();

    encoder_4x2_reg #(.WIDTH_IN(4), .WIDTH_OUT(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] inVal, input logic inValid, input logic outReady);
        busIf.in        = inVal;
        busIf.in_valid  = inValid;
        busIf.out_ready = outReady;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int bumpErr(input int cnt, input logic zero, input logic multi);
        if ((zero || (ONEHOT && multi)) && cnt < 255) return cnt + 1;
        return cnt;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        expErr = 0;

        vecs[0] = '{in: 4'b0001, out: 2'd0, zero: 1'b0, multi: 1'b0};
        vecs[1] = '{in: 4'b1000, out: 2'd3, zero: 1'b0, multi: 1'b0};
        vecs[2] = '{in: 4'b0010, out: 2'd1, zero: 1'b0, multi: 1'b0};
        vecs[3] = '{in: 4'b0100, out: 2'd2, zero: 1'b0, multi: 1'b0};
        vecs[4] = '{in: 4'b0000, out: 2'd0, zero: 1'b1, multi: 1'b0};
        vecs[5] = '{in: 4'b1010, out: 2'd3, zero: 1'b0, multi: 1'b1};
        vecs[6] = '{in: 4'b0011, out: 2'd1, zero: 1'b0, multi: 1'b1};
        vecs[7] = '{in: 4'b0110, out: 2'd2, zero: 1'b0, multi: 1'b1};
        vecs[8] = '{in: 4'b1111, out: 2'd3, zero: 1'b0, multi: 1'b1};
        vecs[9] = '{in: 4'b0101, out: 2'd2, zero: 1'b0, multi: 1'b1};

        rst = 1'b1;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        #1;
        checkOutput("reset out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("reset out", 32'(busIf.out), 32'd0);
        checkOutput("reset zero", 32'(busIf.zero), 32'd0);
        checkOutput("reset err_cnt", 32'(busIf.err_cnt), 32'd0);
`ifdef ONEHOT_CHECK_EN
        checkOutput("reset multi", 32'(busIf.multi), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back stream with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].in, 1'b1, 1'b1);
            #1;
            checkOutput($sformatf("stream[%0d] in_ready", i), 32'(busIf.in_ready), 32'd1);
            expErr = bumpErr(expErr, vecs[i].zero, vecs[i].multi);
            step();
            checkOutput($sformatf("stream[%0d] out_valid", i), 32'(busIf.out_valid), 32'd1);
            checkOutput($sformatf("stream[%0d] out", i), 32'(busIf.out), 32'(vecs[i].out));
            checkOutput($sformatf("stream[%0d] zero", i), 32'(busIf.zero), 32'(vecs[i].zero));
            checkOutput($sformatf("stream[%0d] err_cnt", i), 32'(busIf.err_cnt), 32'(expErr));
`ifdef ONEHOT_CHECK_EN
            checkOutput($sformatf("stream[%0d] multi", i), 32'(busIf.multi), 32'(vecs[i].multi));
`endif
        end

        applyStimulus(4'b0000, 1'b0, 1'b1);
        step();
        checkOutput("drain out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("drain err_cnt", 32'(busIf.err_cnt), 32'(expErr));

        // Backpressure: 2 is held while 1000 waits at the input.
        applyStimulus(4'b0100, 1'b1, 1'b1);
        step();
        checkOutput("bp first out", 32'(busIf.out), 32'd2);
        applyStimulus(4'b1000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("bp[%0d] in_ready", i), 32'(busIf.in_ready), 32'd0);
            step();
            checkOutput($sformatf("bp[%0d] out", i), 32'(busIf.out), 32'd2);
            checkOutput($sformatf("bp[%0d] out_valid", i), 32'(busIf.out_valid), 32'd1);
        end
        applyStimulus(4'b1000, 1'b1, 1'b1);
        #1;
        checkOutput("bp release in_ready", 32'(busIf.in_ready), 32'd1);
        step();
        checkOutput("bp next out", 32'(busIf.out), 32'd3);
        checkOutput("bp next out_valid", 32'(busIf.out_valid), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        step();
        checkOutput("bp drain out_valid", 32'(busIf.out_valid), 32'd0);

        // Asynchronous reset while FULL and stalled.
        applyStimulus(4'b0000, 1'b1, 1'b1);
        step();
        expErr = bumpErr(expErr, 1'b1, 1'b0);
        checkOutput("pre-reset err_cnt", 32'(busIf.err_cnt), 32'(expErr));
        applyStimulus(4'b0001, 1'b1, 1'b0);
        step();
        checkOutput("pre-reset zero held", 32'(busIf.zero), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", 32'(busIf.out_valid), 32'd0);
        checkOutput("async rst out", 32'(busIf.out), 32'd0);
        checkOutput("async rst zero", 32'(busIf.zero), 32'd0);
        checkOutput("async rst err_cnt", 32'(busIf.err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        expErr = 0;
        applyStimulus(4'b0010, 1'b1, 1'b0);
        #1;
        checkOutput("post-reset in_ready", 32'(busIf.in_ready), 32'd1);
        step();
        checkOutput("post-reset out", 32'(busIf.out), 32'd1);
        checkOutput("post-reset out_valid", 32'(busIf.out_valid), 32'd1);

        // Saturation: 300 zero words, the counter must stop at 255.
        applyStimulus(4'b0000, 1'b1, 1'b1);
        for (int k = 1; k <= 300; k++) begin
            step();
            expErr = bumpErr(expErr, 1'b1, 1'b0);
            checkOutput($sformatf("sat[%0d] err_cnt", k), 32'(busIf.err_cnt), 32'(expErr));
        end
        checkOutput("sat final err_cnt", 32'(busIf.err_cnt), 32'd255);
        checkOutput("sat zero", 32'(busIf.zero), 32'd1);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
